// File: rtl/fwd_select_ctrl.sv
// EX-stage operand forwarding select, load-use stall detection and the
// post-WB data buffer feeding mux input 3 (register file has no write-through).
module fwd_select_ctrl #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [RAW-1:0]  id_rs1_i,
    input  logic [RAW-1:0]  id_rs2_i,
    input  logic [RAW-1:0]  id_rd_i,
    input  logic            id_regwrite_i,
    input  logic            id_memread_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o,
    output logic [XLEN-1:0] wb1_data_o,
    output logic            hazard_stall_o
);

    // Load status only matters while the load sits in EX; later stages drop it.
    typedef struct packed {
        logic           valid;
        logic           regwrite;
        logic [RAW-1:0] rd;
    } dst_t;

    logic            ex_valid;
    logic            ex_regwrite;
    logic            ex_memread;
    logic [RAW-1:0]  ex_rd;
    logic [RAW-1:0]  ex_rs1;
    logic [RAW-1:0]  ex_rs2;
    dst_t            mem_q;
    dst_t            wb_q;
    dst_t            wb1_q;
    logic [XLEN-1:0] wb1_data_q;
    logic            insert_bubble;

    function automatic logic stage_hit(input dst_t s, input logic [RAW-1:0] rs);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
    endfunction

    assign insert_bubble = flush_i | hazard_stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            wb1_q       <= '0;
            wb1_data_q  <= '0;
        end else if (!stall_i) begin
            wb1_q      <= wb_q;
            wb_q       <= mem_q;
            mem_q      <= '{valid: ex_valid, regwrite: ex_regwrite, rd: ex_rd};
            wb1_data_q <= wb_data_i;
            if (insert_bubble) begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rd       <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
            end else begin
                ex_valid    <= id_valid_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
                ex_rd       <= id_rd_i;
                ex_rs1      <= id_rs1_i;
                ex_rs2      <= id_rs2_i;
            end
        end
    end

    // Youngest producer wins: MEM, then WB, then the post-WB buffer.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (ex_valid) begin
            if (stage_hit(mem_q, ex_rs1))      fwd_a_o = 2'b10;
            else if (stage_hit(wb_q, ex_rs1))  fwd_a_o = 2'b01;
            else if (stage_hit(wb1_q, ex_rs1)) fwd_a_o = 2'b11;

            if (stage_hit(mem_q, ex_rs2))      fwd_b_o = 2'b10;
            else if (stage_hit(wb_q, ex_rs2))  fwd_b_o = 2'b01;
            else if (stage_hit(wb1_q, ex_rs2)) fwd_b_o = 2'b11;
        end
    end

    assign hazard_stall_o = id_valid_i && ex_valid && ex_memread && (ex_rd != '0) &&
                            ((ex_rd == id_rs1_i) || (ex_rd == id_rs2_i));

    assign wb1_data_o = wb1_data_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed bench for fwd_select_ctrl: expected outputs are queued as each
// step is driven and popped when the outputs are sampled.
module tb_fwd_select_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic [31:0] wb_data_i;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [31:0] wb1_data_o;
    logic        hazard_stall_o;

    fwd_select_ctrl #(.XLEN(32), .RAW(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .wb_data_i      (wb_data_i),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .wb1_data_o     (wb1_data_o),
        .hazard_stall_o (hazard_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        hz;
        logic [31:0] wd;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_wb1  = '0;

    task automatic push_exp(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic hz, input logic [31:0] wd);
        exp_t e;
        e.fa = fa; e.fb = fb; e.hz = hz; e.wd = wd; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert (fwd_a_o === e.fa) else begin
            n_fail++;
            $error("FAIL %s fwd_a observed=%b expected=%b", e.tag, fwd_a_o, e.fa);
        end
        n_checks++;
        assert (fwd_b_o === e.fb) else begin
            n_fail++;
            $error("FAIL %s fwd_b observed=%b expected=%b", e.tag, fwd_b_o, e.fb);
        end
        n_checks++;
        assert (hazard_stall_o === e.hz) else begin
            n_fail++;
            $error("FAIL %s hazard observed=%b expected=%b", e.tag, hazard_stall_o, e.hz);
        end
        n_checks++;
        assert (wb1_data_o === e.wd) else begin
            n_fail++;
            $error("FAIL %s wb1_data observed=%h expected=%h", e.tag, wb1_data_o, e.wd);
        end
    endtask

    // Drive ID and WB data, check outputs for the current state, then clock once.
    task automatic step(input string tag, input logic v, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic [31:0] wd, input logic [1:0] efa,
                        input logic [1:0] efb, input logic ehz);
        id_valid_i    = v;
        id_rs1_i      = r1;
        id_rs2_i      = r2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        wb_data_i     = wd;
        push_exp(tag, efa, efb, ehz, exp_wb1);
        #1;
        check();
        @(posedge clk_i);
        if (!stall_i) exp_wb1 = wd;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        id_valid_i = 1'b1; id_rs1_i = 5'd9; id_rs2_i = 5'd9; id_rd_i = 5'd9;
        id_regwrite_i = 1'b1; id_memread_i = 1'b1; wb_data_i = 32'hFFFF_FFFF;
        push_exp("reset", 2'b00, 2'b00, 1'b0, 32'h0);
        #1;
        check();
        #2 rst_i = 1'b1;

        // producer in MEM forwards, then drops away for an unrelated consumer
        step("t1_add",    1, 5'd1,  5'd2,  5'd5,  1, 0, 32'h0000_0101, 2'b00, 2'b00, 0);
        step("t1_sub_id", 1, 5'd5,  5'd6,  5'd8,  1, 0, 32'h0000_0102, 2'b00, 2'b00, 0);
        step("t1_sub_ex", 1, 5'd10, 5'd11, 5'd12, 1, 0, 32'h0000_0103, 2'b10, 2'b00, 0);
        // producer x7 travels to WB1, consumer rs2 picks the buffer
        step("t1_unrel",  1, 5'd0,  5'd0,  5'd7,  1, 0, 32'h0000_0104, 2'b00, 2'b00, 0);
        step("t2_p7_ex",  1, 5'd13, 5'd14, 5'd15, 1, 0, 32'h0000_0105, 2'b00, 2'b00, 0);
        step("t2_u1_ex",  1, 5'd16, 5'd17, 5'd18, 1, 0, 32'h0000_0106, 2'b00, 2'b00, 0);
        step("t2_u2_ex",  1, 5'd1,  5'd7,  5'd19, 1, 0, 32'hDEAD_BEEF, 2'b00, 2'b00, 0);
        step("t2_wb1",    1, 5'd0,  5'd0,  5'd3,  1, 0, 32'h0000_0108, 2'b00, 2'b11, 0);
        // two producers of x3: youngest (MEM) wins; x0 never forwards
        step("t3_p3a_ex", 1, 5'd0,  5'd0,  5'd3,  1, 0, 32'h0000_0109, 2'b00, 2'b00, 0);
        step("t3_p3b_ex", 1, 5'd3,  5'd20, 5'd21, 1, 0, 32'h0000_010A, 2'b00, 2'b00, 0);
        step("t3_young",  1, 5'd0,  5'd0,  5'd0,  1, 0, 32'h0000_010B, 2'b10, 2'b00, 0);
        step("t3_x0_ex",  1, 5'd0,  5'd0,  5'd22, 1, 0, 32'h0000_010C, 2'b00, 2'b00, 0);
        step("t3_x0_use", 1, 5'd2,  5'd0,  5'd9,  1, 1, 32'h0000_010D, 2'b00, 2'b00, 0);
        // load-use: stall request, bubble, then WB forward
        step("t4_hazard", 1, 5'd1,  5'd9,  5'd23, 1, 0, 32'h0000_010E, 2'b00, 2'b00, 1);
        step("t4_bubble", 1, 5'd1,  5'd9,  5'd23, 1, 0, 32'h0000_010F, 2'b00, 2'b00, 0);
        step("t4_fwd_wb", 1, 5'd23, 5'd9,  5'd27, 1, 0, 32'h1234_5678, 2'b00, 2'b01, 0);
        // global freeze with matches pending
        stall_i = 1'b1;
        step("t5_hold0",  1, 5'd28, 5'd29, 5'd30, 1, 0, 32'hAAAA_5555, 2'b10, 2'b11, 0);
        step("t5_hold1",  1, 5'd28, 5'd29, 5'd30, 1, 0, 32'hAAAA_5555, 2'b10, 2'b11, 0);
        step("t5_hold2",  1, 5'd28, 5'd29, 5'd30, 1, 0, 32'hAAAA_5555, 2'b10, 2'b11, 0);
        stall_i = 1'b0;
        step("t5_release",1, 5'd27, 5'd0,  5'd31, 1, 0, 32'hAAAA_5555, 2'b10, 2'b11, 0);
        step("t5_advance",1, 5'd23, 5'd27, 5'd1,  1, 0, 32'h0000_0115, 2'b10, 2'b00, 0);
        // flush discards a valid ID instruction
        flush_i = 1'b1;
        step("t6_pre_fl", 1, 5'd31, 5'd0,  5'd2,  1, 0, 32'h0000_0116, 2'b11, 2'b01, 0);
        flush_i = 1'b0;
        step("t6_flushed",1, 5'd1,  5'd31, 5'd3,  1, 0, 32'h0000_0117, 2'b00, 2'b00, 0);
        step("t6_after",  1, 5'd0,  5'd0,  5'd0,  0, 0, 32'h0000_0118, 2'b01, 2'b11, 0);

        // async reset mid-cycle, no clock edge needed
        #3 rst_i = 1'b0;
        exp_wb1 = '0;
        push_exp("t6_async_rst", 2'b00, 2'b00, 1'b0, 32'h0);
        #1;
        check();
        #1 rst_i = 1'b1;
        step("t6_post_ld", 1, 5'd0, 5'd0,  5'd4,  1, 1, 32'h0000_0119, 2'b00, 2'b00, 0);
        step("t6_post_hz", 1, 5'd4, 5'd0,  5'd5,  1, 0, 32'h0000_011A, 2'b00, 2'b00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
